// File: rtl/cpld_mrd_req_scheduler.sv
// MRd issuer: splits read commands into chunks bounded by MRRS, the 4 KB boundary and the
// completion-buffer budget, tracking tags until their final CplD. Optional counters: CPLD_MRD_STATS_EN.
module cpld_mrd_req_scheduler #(
  parameter int          MAX_NUMTAG = 32,
  parameter int          SETTLE_CYC = 6,
  parameter logic [15:0] REQ_ID     = 16'h0000
) (
  input  logic         clk_in,
  input  logic         srst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [63:0]  cmd_addr,
  input  logic [15:0]  cmd_len_dw,
  input  logic [10:0]  cfg_max_rd_req_dw,
  input  logic [15:0]  rx_buffer_cpl_max_dw,
  input  logic         cpld_rx_buffer_ready,
  output logic         tx_req0,
  input  logic         tx_ack0,
  output logic [127:0] tx_desc0,
  input  logic         rx_ack0,
  input  logic [135:0] rx_desc0,
  output logic [8:0]   tags_outstanding,
  output logic         cmd_done,
  output logic         tag_err
`ifdef CPLD_MRD_STATS_EN
  ,
  output logic [31:0]  stat_mrd_cnt,
  output logic [31:0]  stat_stall_cnt
`endif
);

  // Handshakes: a command transfers on cmd_valid&cmd_ready; tx_req0 holds tx_desc0 stable
  // until the cycle tx_ack0 is sampled high, then drops the next cycle.
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_REQ, S_SETTLE, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [63:0]           addr_q, addr_d;
  logic [15:0]           rem_q, rem_d, chunk_q, chunk_d, settle_q, settle_d;
  logic [7:0]            tag_q, tag_d, cpl_tag_q, cpl_tag_d;
  logic [127:0]          desc_q, desc_d;
  logic [MAX_NUMTAG-1:0] used_q, used_d;
  logic [8:0]            cnt_q, cnt_d;
  logic                  done_q, done_d, err_q, err_d, cpl_v_q, cpl_v_d;

  logic [15:0] bnd_dw, chunk;
  logic [12:0] cpl_bytes;
  logic [7:0]  free_tag;
  logic        free_found, go, alloc, rel, cpl_hit, cpl_last, four_dw;
  logic        unused_bits;

  assign unused_bits = ^{cmd_addr[1:0], rx_desc0[135:127], rx_desc0[120:106],
                         rx_desc0[95:76], rx_desc0[63:48], rx_desc0[39:0]};

  always_comb begin
    // A zero length field means 1024 DW, which always covers the remaining byte count.
    cpl_bytes = (rx_desc0[105:96] == 10'd0) ? 13'd4096 : {1'b0, rx_desc0[105:96], 2'b00};
    cpl_last  = cpl_bytes >= {1'b0, rx_desc0[75:64]};
    cpl_v_d   = rx_ack0 && (rx_desc0[126:121] == 6'b100101) && cpl_last;
    cpl_tag_d = rx_desc0[47:40];

    bnd_dw = 16'((13'd4096 - {1'b0, addr_q[11:0]}) >> 2);
    chunk  = rem_q;
    if ({5'd0, cfg_max_rd_req_dw} < chunk) chunk = {5'd0, cfg_max_rd_req_dw};
    if (rx_buffer_cpl_max_dw < chunk) chunk = rx_buffer_cpl_max_dw;
    if (bnd_dw < chunk) chunk = bnd_dw;

    free_found = 1'b0;
    free_tag   = '0;
    for (int i = MAX_NUMTAG - 1; i >= 0; i--) begin
      if (!used_q[i]) begin
        free_found = 1'b1;
        free_tag   = 8'(i);
      end
    end
    cpl_hit = 1'b0;
    for (int i = 0; i < MAX_NUMTAG; i++) begin
      if (cpl_tag_q == 8'(i) && used_q[i]) cpl_hit = 1'b1;
    end

    go      = (chunk != 16'd0) && cpld_rx_buffer_ready && free_found;
    four_dw = addr_q[63:32] != 32'd0;

    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    chunk_d  = chunk_q;
    tag_d    = tag_q;
    desc_d   = desc_q;
    settle_d = settle_q;
    done_d   = 1'b0;
    alloc    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len_dw == 16'd0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = {cmd_addr[63:2], 2'b00};
            rem_d   = cmd_len_dw;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (go) begin
          chunk_d             = chunk;
          tag_d               = free_tag;
          desc_d              = '0;
          desc_d[126:120]     = four_dw ? 7'b0100000 : 7'b0000000;
          desc_d[105:96]      = chunk[9:0];
          desc_d[95:80]       = REQ_ID;
          desc_d[79:72]       = free_tag;
          desc_d[71:64]       = (chunk == 16'd1) ? 8'h0F : 8'hFF;
          desc_d[63:0]        = four_dw ? addr_q : {addr_q[31:0], 32'h0};
          state_d             = S_REQ;
        end
      end
      S_REQ: begin
        if (tx_ack0) begin
          alloc    = 1'b1;
          addr_d   = addr_q + {46'd0, chunk_q, 2'b00};
          rem_d    = rem_q - chunk_q;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == 16'(SETTLE_CYC - 1)) begin
          state_d = (rem_q != 16'd0) ? S_CALC : S_DRAIN;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == 9'd0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rel    = cpl_v_q && cpl_hit;
    err_d  = err_q | (cpl_v_q && !cpl_hit);
    used_d = used_q;
    for (int i = 0; i < MAX_NUMTAG; i++) begin
      if (rel && cpl_tag_q == 8'(i)) used_d[i] = 1'b0;
      if (alloc && tag_q == 8'(i)) used_d[i] = 1'b1;
    end
    cnt_d = cnt_q + {8'd0, alloc} - {8'd0, rel};
  end

  always_ff @(posedge clk_in) begin
    if (srst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      chunk_q   <= '0;
      tag_q     <= '0;
      desc_q    <= '0;
      settle_q  <= '0;
      used_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpl_v_q   <= 1'b0;
      cpl_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      chunk_q   <= chunk_d;
      tag_q     <= tag_d;
      desc_q    <= desc_d;
      settle_q  <= settle_d;
      used_q    <= used_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cpl_v_q   <= cpl_v_d;
      cpl_tag_q <= cpl_tag_d;
    end
  end

  assign cmd_ready        = (state_q == S_IDLE) && !srst;
  assign tx_req0          = (state_q == S_REQ);
  assign tx_desc0         = desc_q;
  assign tags_outstanding = cnt_q;
  assign cmd_done         = done_q;
  assign tag_err          = err_q;

`ifdef CPLD_MRD_STATS_EN
  logic [31:0] mrd_q, mrd_d, stall_q, stall_d;

  always_comb begin
    mrd_d   = mrd_q;
    stall_d = stall_q;
    if (alloc && mrd_q != '1) mrd_d = mrd_q + 32'd1;
    if (state_q == S_CALC && !go && stall_q != '1) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_in) begin
    if (srst) begin
      mrd_q   <= '0;
      stall_q <= '0;
    end else begin
      mrd_q   <= mrd_d;
      stall_q <= stall_d;
    end
  end

  assign stat_mrd_cnt   = mrd_q;
  assign stat_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cpld_mrd_req_scheduler.sv
// Directed bench for cpld_mrd_req_scheduler: a transaction-level model predicts each MRd
// descriptor, tag usage and error flag; literal descriptors pin the model on key cases.
module tb_cpld_mrd_req_scheduler;
  localparam int NT = 2;
  localparam int SETTLE = 6;
  localparam logic [15:0] RID = 16'h0000;

  logic         clk_in = 1'b0;
  logic         srst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [63:0]  cmd_addr;
  logic [15:0]  cmd_len_dw;
  logic [10:0]  cfg_max_rd_req_dw;
  logic [15:0]  rx_buffer_cpl_max_dw;
  logic         cpld_rx_buffer_ready;
  logic         tx_req0;
  logic         tx_ack0;
  logic [127:0] tx_desc0;
  logic         rx_ack0;
  logic [135:0] rx_desc0;
  logic [8:0]   tags_outstanding;
  logic         cmd_done;
  logic         tag_err;
`ifdef CPLD_MRD_STATS_EN
  logic [31:0]  stat_mrd_cnt;
  logic [31:0]  stat_stall_cnt;
`endif

  cpld_mrd_req_scheduler #(.MAX_NUMTAG(NT), .SETTLE_CYC(SETTLE), .REQ_ID(RID)) dut (
    .clk_in(clk_in), .srst(srst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len_dw(cmd_len_dw), .cfg_max_rd_req_dw(cfg_max_rd_req_dw),
    .rx_buffer_cpl_max_dw(rx_buffer_cpl_max_dw), .cpld_rx_buffer_ready(cpld_rx_buffer_ready),
    .tx_req0(tx_req0), .tx_ack0(tx_ack0), .tx_desc0(tx_desc0), .rx_ack0(rx_ack0),
    .rx_desc0(rx_desc0), .tags_outstanding(tags_outstanding), .cmd_done(cmd_done),
    .tag_err(tag_err)
`ifdef CPLD_MRD_STATS_EN
    , .stat_mrd_cnt(stat_mrd_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  // clock
  always #5 clk_in = ~clk_in;

  // model state and scoreboard
  logic [63:0]  m_addr;
  logic [15:0]  m_rem;
  bit           m_used[NT];
  int           m_cnt;
  bit           m_err;
  int           issued_total, done_cnt, ack_limit, ack_delay;
  int           n_cmp, n_err;
  int           stall_hits, base, d0;
  logic [127:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_chunk();
    logic [63:0] c, room;
    room = (64'd4096 - (m_addr % 64'd4096)) / 64'd4;
    c = 64'(m_rem);
    if (64'(cfg_max_rd_req_dw) < c) c = 64'(cfg_max_rd_req_dw);
    if (64'(rx_buffer_cpl_max_dw) < c) c = 64'(rx_buffer_cpl_max_dw);
    if (room < c) c = room;
    return c;
  endfunction

  function automatic int model_tag();
    for (int i = 0; i < NT; i++) if (!m_used[i]) return i;
    return 0;
  endfunction

  function automatic logic [127:0] model_desc();
    logic [127:0] d;
    logic [63:0]  c;
    bit           hi;
    c  = model_chunk();
    hi = m_addr > 64'hFFFF_FFFF;
    d  = '0;
    d[126:120] = hi ? 7'b0100000 : 7'b0000000;
    d[105:96]  = 10'(c % 64'd1024);
    d[95:80]   = RID;
    d[79:72]   = 8'(model_tag());
    d[71:64]   = (c == 64'd1) ? 8'h0F : 8'hFF;
    d[63:0]    = hi ? m_addr : (m_addr << 32);
    return d;
  endfunction

  task automatic model_issue();
    logic [63:0] c;
    int t;
    c = model_chunk();
    t = model_tag();
    m_used[t] = 1'b1;
    m_cnt++;
    m_addr = m_addr + c * 64'd4;
    m_rem  = m_rem - 16'(c);
    issued_total++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_used[i] = 1'b0;
    m_cnt = 0; m_err = 1'b0; m_rem = '0; m_addr = '0;
    exp_q.delete();
  endtask

  // compare process: descriptor checked every cycle tx_req0 is high; also drives tx_ack0
  task automatic compare_loop();
    int waitc = 0;
    forever begin
      @(negedge clk_in);
      if (cmd_done) done_cnt++;
      if (tx_ack0) begin
        tx_ack0 = 1'b0;
        waitc = 0;
      end else if (!srst && tx_req0) begin
        chk("desc_model", tx_desc0, model_desc());
        if (issued_total < ack_limit) begin
          if (waitc >= ack_delay) begin
            if (exp_q.size() > 0) chk("desc_literal", tx_desc0, exp_q.pop_front());
            model_issue();
            tx_ack0 = 1'b1;
            waitc = 0;
          end else begin
            waitc++;
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_cmd(input logic [63:0] addr, input logic [15:0] len);
    int k = 0;
    @(negedge clk_in);
    while (!cmd_ready && k < 300) begin
      @(negedge clk_in);
      k++;
    end
    chk("cmd_ready_wait", 128'(cmd_ready), 128'd1);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len_dw = len;
    if (len != 16'd0) begin
      m_addr = {addr[63:2], 2'b00};
      m_rem  = len;
    end
    @(negedge clk_in);
    cmd_valid = 1'b0;
  endtask

  task automatic send_cpl(input int tag, input int len, input int bc, input bit cpld);
    int  lb;
    bit  last;
    @(negedge clk_in);
    rx_desc0 = '0;
    rx_desc0[126:121] = cpld ? 6'b100101 : 6'b000101;
    rx_desc0[105:96]  = 10'(len);
    rx_desc0[75:64]   = 12'(bc);
    rx_desc0[47:40]   = 8'(tag);
    rx_ack0 = 1'b1;
    @(negedge clk_in);
    rx_ack0 = 1'b0;
    rx_desc0 = '0;
    lb = (len == 0) ? 4096 : len * 4;
    last = lb >= bc;
    if (cpld && last) begin
      if (tag < NT && m_used[tag]) begin
        m_used[tag] = 1'b0;
        m_cnt--;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic wait_issued(input int n, input string name);
    int k = 0;
    while (issued_total < n && k < 400) begin
      @(negedge clk_in);
      k++;
    end
    chk(name, 128'(issued_total), 128'(n));
  endtask

  task automatic wait_done(input int n, input string name);
    int k = 0;
    while (done_cnt < n && k < 400) begin
      @(negedge clk_in);
      k++;
    end
    cycles(5);
    chk(name, 128'(done_cnt), 128'(n));
  endtask

  task automatic stall_window();
    stall_hits = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (tx_req0) stall_hits++;
    end
    chk("stall_no_req", 128'(stall_hits), 128'd0);
  endtask

  initial begin
    srst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len_dw = '0;
    cfg_max_rd_req_dw = 11'd128; rx_buffer_cpl_max_dw = 16'hFFFF; cpld_rx_buffer_ready = 1'b1;
    tx_ack0 = 1'b0; rx_ack0 = 1'b0; rx_desc0 = '0;
    n_cmp = 0; n_err = 0; issued_total = 0; done_cnt = 0;
    ack_limit = 1000000; ack_delay = 0;
    model_reset();
    fork
      compare_loop();
      begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
      end
    join_none

    // reset state
    cycles(3);
    chk("rst_cmd_ready_low", 128'(cmd_ready), 128'd0);
    srst = 1'b0;
    cycles(1);
    chk("rst_cmd_ready", 128'(cmd_ready), 128'd1);
    chk("rst_tx_req", 128'(tx_req0), 128'd0);
    chk("rst_desc", tx_desc0, 128'd0);
    chk("rst_outst", 128'(tags_outstanding), 128'd0);
    chk("rst_done", 128'(cmd_done), 128'd0);
    chk("rst_tag_err", 128'(tag_err), 128'd0);

    // two 128-DW chunks, tags 0 and 1
    base = issued_total; d0 = done_cnt;
    exp_q.push_back(128'h00000080_000000FF_00001000_00000000);
    exp_q.push_back(128'h00000080_000001FF_00001200_00000000);
    send_cmd(64'h1000, 16'd256);
    wait_issued(base + 2, "t1_issued");
    cycles(10);
    chk("t1_outst2", 128'(tags_outstanding), 128'd2);
    send_cpl(0, 64, 512, 1'b1);
    cycles(4);
    chk("t1_partial_keeps", 128'(tags_outstanding), 128'd2);
    send_cpl(0, 64, 256, 1'b1);
    send_cpl(1, 128, 512, 1'b1);
    wait_done(d0 + 1, "t1_done_once");
    chk("t1_outst0", 128'(tags_outstanding), 128'(m_cnt));

    // 4 KB boundary split, delayed ack exercises descriptor hold
    base = issued_total; d0 = done_cnt; ack_delay = 3;
    exp_q.push_back(128'h00000004_000000FF_00000FF0_00000000);
    exp_q.push_back(128'h0000000C_000001FF_00001000_00000000);
    send_cmd(64'hFF0, 16'd16);
    wait_issued(base + 2, "t2_issued");
    cycles(10);
    send_cpl(0, 4, 16, 1'b1);
    send_cpl(1, 12, 48, 1'b1);
    wait_done(d0 + 1, "t2_done");
    ack_delay = 0;

    // 4DW single-DW read; low address bits ignored; non-CplD does not free
    base = issued_total; d0 = done_cnt;
    exp_q.push_back(128'h20000001_0000000F_00000001_00000000);
    send_cmd(64'h1_0000_0003, 16'd1);
    wait_issued(base + 1, "t3_issued");
    cycles(10);
    send_cpl(0, 1, 4, 1'b0);
    cycles(4);
    chk("t3_cpl_nodata", 128'(tags_outstanding), 128'd1);
    send_cpl(0, 1, 4, 1'b1);
    wait_done(d0 + 1, "t3_done");

    // budget stall then budget 64
    base = issued_total; d0 = done_cnt;
    rx_buffer_cpl_max_dw = 16'd0;
    send_cmd(64'h2000, 16'd64);
    stall_window();
`ifdef CPLD_MRD_STATS_EN
    chk("t4_stall_stat", 128'(stat_stall_cnt >= 32'd20), 128'd1);
`endif
    exp_q.push_back(128'h00000040_000000FF_00002000_00000000);
    rx_buffer_cpl_max_dw = 16'd64;
    wait_issued(base + 1, "t4_issued");
    cycles(10);
    send_cpl(0, 64, 256, 1'b1);
    wait_done(d0 + 1, "t4_done");

    // ready stall
    base = issued_total; d0 = done_cnt;
    cpld_rx_buffer_ready = 1'b0;
    send_cmd(64'h3000, 16'd64);
    stall_window();
    exp_q.push_back(128'h00000040_000000FF_00003000_00000000);
    cpld_rx_buffer_ready = 1'b1;
    wait_issued(base + 1, "t4b_issued");
    cycles(10);
    send_cpl(0, 64, 256, 1'b1);
    wait_done(d0 + 1, "t4b_done");
    rx_buffer_cpl_max_dw = 16'hFFFF;
`ifdef CPLD_MRD_STATS_EN
    chk("stat_mrd", 128'(stat_mrd_cnt), 128'(issued_total));
`endif

    // pool exhaustion: two tags, four chunks
    base = issued_total; d0 = done_cnt;
    send_cmd(64'h4000, 16'd512);
    wait_issued(base + 2, "t5_issued2");
    cycles(30);
    chk("t5_stalled", 128'(issued_total), 128'(base + 2));
    chk("t5_outst_full", 128'(tags_outstanding), 128'd2);
    exp_q.push_back(128'h00000080_000000FF_00004400_00000000);
    send_cpl(0, 128, 512, 1'b1);
    wait_issued(base + 3, "t5_issued3");
    cycles(10);
    exp_q.push_back(128'h00000080_000001FF_00004600_00000000);
    send_cpl(1, 128, 512, 1'b1);
    wait_issued(base + 4, "t5_issued4");
    cycles(10);
    send_cpl(0, 128, 512, 1'b1);
    send_cpl(1, 0, 512, 1'b1);
    wait_done(d0 + 1, "t5_done");

    // unknown tags
    chk("t6_err_clear", 128'(tag_err), 128'd0);
    send_cpl(5, 1, 4, 1'b1);
    cycles(4);
    chk("t6_err_set", 128'(tag_err), 128'(m_err));
    chk("t6_err_literal", 128'(tag_err), 128'd1);
    chk("t6_outst", 128'(tags_outstanding), 128'd0);
    send_cpl(1, 1, 4, 1'b1);
    cycles(10);
    chk("t6_err_sticky", 128'(tag_err), 128'd1);

    // reset while a request is held
    base = issued_total;
    ack_limit = issued_total + 1;
    send_cmd(64'h5000, 16'd256);
    wait_issued(base + 1, "t7_first");
    cycles(12);
    chk("t7_req_held", 128'(tx_req0), 128'd1);
    chk("t7_outst1", 128'(tags_outstanding), 128'd1);
    srst = 1'b1;
    cycles(1);
    chk("t7_rdy_in_rst", 128'(cmd_ready), 128'd0);
    srst = 1'b0;
    model_reset();
    ack_limit = 1000000;
    cycles(1);
    chk("t7_req_low", 128'(tx_req0), 128'd0);
    chk("t7_outst0", 128'(tags_outstanding), 128'd0);
    chk("t7_err_clr", 128'(tag_err), 128'd0);
    chk("t7_rdy", 128'(cmd_ready), 128'd1);
    chk("t7_desc0", tx_desc0, 128'd0);
    send_cpl(0, 128, 512, 1'b1);
    cycles(4);
    chk("t7_old_tag_err", 128'(tag_err), 128'(m_err));
    chk("t7_old_tag_outst", 128'(tags_outstanding), 128'd0);

    // zero-length command
    base = issued_total; d0 = done_cnt;
    send_cmd(64'h6000, 16'd0);
    cycles(3);
    chk("t8_done_pulse", 128'(done_cnt), 128'(d0 + 1));
    chk("t8_no_issue", 128'(issued_total), 128'(base));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
